uart_tx_frame_ctrl: RTL and testbench

//   Frame controller and serializer for the UART transmitter; directly upstream of the TX output mux.
//   - Accepts a parallel byte, computes optional parity and steps a Moore FSM through START/DATA/PARITY/STOP.
//   - Drives mux_sel, ser_data and Par_bit into the mux, which forms TX_out.
//   - One CLK cycle = one bit period; the baud-rate clock is generated outside this block.

---
 rtl/uart_tx_frame_ctrl.sv | 125 ++++++++++++
 tb/tb_uart_tx_frame_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: latches a payload, walks START/DATA/PARITY/STOP
// one bit period per clock and feeds the TX output mux with registered selects.
module uart_tx_frame_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  Par_bit,
  output logic                  busy
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_STOP   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  ser_data_q, ser_data_d;
  logic [1:0]            mux_sel_q, mux_sel_d;
  logic                  busy_q, busy_d;

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case
    // leaves a variable unassigned and infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    ser_data_d = ser_data_q;

    case (state_q)
      IDLE: begin
        if (Data_Valid) begin
          data_d    = P_DATA;
          par_en_d  = PAR_EN;
          par_bit_d = (^P_DATA) ^ PAR_TYP;
          state_d   = START;
        end
      end
      START: begin
        state_d    = DATA;
        cnt_d      = '0;
        ser_data_d = data_q[0];
      end
      DATA: begin
        // The counter parks on the last index; START clears it for the next frame.
        if (cnt_q == CNT_LAST) begin
          state_d = par_en_q ? PARITY : STOP;
        end else begin
          cnt_d      = cnt_q + 1'b1;
          ser_data_d = data_q[cnt_d];
        end
      end
      PARITY:  state_d = STOP;
      STOP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    mux_sel_d = SEL_STOP;
    busy_d    = 1'b1;
    case (state_d)
      IDLE:    begin mux_sel_d = SEL_STOP; busy_d = 1'b0; end
      START:   mux_sel_d = SEL_START;
      DATA:    mux_sel_d = SEL_DATA;
      PARITY:  mux_sel_d = SEL_PARITY;
      STOP:    mux_sel_d = SEL_STOP;
      default: begin mux_sel_d = SEL_STOP; busy_d = 1'b0; end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // its pre-edge value, independent of statement order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the payload register is reset too, so a frame abandoned by RST
      // leaves no stale data behind.
      state_q    <= IDLE;
      cnt_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      ser_data_q <= 1'b0;
      mux_sel_q  <= SEL_STOP;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      ser_data_q <= ser_data_d;
      mux_sel_q  <= mux_sel_d;
      busy_q     <= busy_d;
    end
  end

  assign mux_sel  = mux_sel_q;
  assign ser_data = ser_data_q;
  assign Par_bit  = par_bit_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Self-checking bench for uart_tx_frame_ctrl: directed scenarios plus random
// traffic, compared every cycle against a frame-list reference model.
module tb_uart_tx_frame_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       Data_Valid;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [1:0] mux_sel;
  logic       ser_data;
  logic       Par_bit;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_tx_frame_ctrl #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .mux_sel    (mux_sel),
    .ser_data   (ser_data),
    .Par_bit    (Par_bit),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  // Reference model: a frame is a list of bit-period slots built at accept time.
  typedef struct {
    logic [1:0] sel;
    logic       bit_val;
  } slot_t;

  slot_t      frame_q[$];
  logic [1:0] e_sel  = 2'b01;
  logic       e_busy = 1'b0;
  logic       e_ser  = 1'b0;
  logic       e_par  = 1'b0;

  // Line monitor: busy run length and recent line history.
  int          run_len  = 0;
  int          last_len = 0;
  logic [15:0] line_hist = '0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic rst, input logic dv, input logic [7:0] d,
                            input logic pe, input logic pt);
    slot_t s;
    if (rst) begin
      frame_q.delete();
      e_sel  = 2'b01;
      e_busy = 1'b0;
      e_ser  = 1'b0;
      e_par  = 1'b0;
    end else begin
      if (!e_busy && dv) begin
        e_par = (^d) ^ pt;
        frame_q.push_back('{sel: 2'b00, bit_val: 1'b0});
        for (int i = 0; i < 8; i++) frame_q.push_back('{sel: 2'b10, bit_val: d[i]});
        if (pe) frame_q.push_back('{sel: 2'b11, bit_val: e_par});
        frame_q.push_back('{sel: 2'b01, bit_val: 1'b1});
      end
      if (frame_q.size() > 0) begin
        s      = frame_q.pop_front();
        e_sel  = s.sel;
        e_busy = 1'b1;
        if (s.sel == 2'b10) e_ser = s.bit_val;
      end else begin
        e_sel  = 2'b01;
        e_busy = 1'b0;
      end
    end
  endtask

  task automatic compare();
    logic line;
    check("mux_sel", 16'(mux_sel), 16'(e_sel));
    check("busy", 16'(busy), 16'(e_busy));
    check("ser_data", 16'(ser_data), 16'(e_ser));
    check("Par_bit", 16'(Par_bit), 16'(e_par));
    case (mux_sel)
      2'b00:   line = 1'b0;
      2'b01:   line = 1'b1;
      2'b10:   line = ser_data;
      default: line = Par_bit;
    endcase
    line_hist = {line_hist[14:0], line};
    if (busy) begin
      run_len++;
    end else if (run_len > 0) begin
      last_len = run_len;
      run_len  = 0;
    end
  endtask

  // Drive inputs, take one edge, advance the model, sample on the falling edge.
  task automatic step(input logic rst, input logic dv, input logic [7:0] d,
                      input logic pe, input logic pt);
    RST = rst; Data_Valid = dv; P_DATA = d; PAR_EN = pe; PAR_TYP = pt;
    @(posedge CLK);
    model_edge(rst, dv, d, pe, pt);
    @(negedge CLK);
    compare();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
  endtask

  initial begin
    RST = 1'b1; Data_Valid = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    @(negedge CLK);
    step(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("reset_mux_sel", 16'(mux_sel), 16'h1);
    check("reset_busy", 16'(busy), 16'h0);
    check("reset_par", 16'(Par_bit), 16'h0);
    check("reset_ser", 16'(ser_data), 16'h0);

    // 0xA5 without parity: ten busy cycles, line 0,1,0,1,0,0,1,0,1,1 then idle high.
    step(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0);
    idle(10);
    check("t1_len", 16'(last_len), 16'd10);
    check("t1_line", 16'(line_hist[10:0]), 16'(11'b01010010111));

    // 0xA5 with even then odd parity.
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b0);
    idle(11);
    check("t2_len_even", 16'(last_len), 16'd11);
    check("t2_par_even", 16'(Par_bit), 16'h0);
    step(1'b0, 1'b1, 8'hA5, 1'b1, 1'b1);
    idle(11);
    check("t2_len_odd", 16'(last_len), 16'd11);
    check("t2_par_odd", 16'(Par_bit), 16'h1);

    // Parity corner values.
    step(1'b0, 1'b1, 8'h01, 1'b1, 1'b0);
    idle(11);
    check("t3_par_01_even", 16'(Par_bit), 16'h1);
    step(1'b0, 1'b1, 8'hFF, 1'b1, 1'b1);
    idle(11);
    check("t3_par_ff_odd", 16'(Par_bit), 16'h1);
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
    idle(11);
    check("t3_par_00_even", 16'(Par_bit), 16'h0);

    // Data_Valid held high with P_DATA changing every cycle.
    for (int i = 0; i < 34; i++) step(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0);
    idle(12);

    // Reset during DATA bit 3, then a clean 0x3C frame with even parity.
    step(1'b0, 1'b1, 8'h5A, 1'b1, 1'b1);
    idle(4);
    check("t5_in_data", 16'(mux_sel), 16'h2);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    check("t5_rst_mux", 16'(mux_sel), 16'h1);
    check("t5_rst_busy", 16'(busy), 16'h0);
    check("t5_rst_par", 16'(Par_bit), 16'h0);
    step(1'b0, 1'b1, 8'h3C, 1'b1, 1'b0);
    idle(11);
    check("t5_len", 16'(last_len), 16'd11);
    check("t5_par", 16'(Par_bit), 16'h0);

    // Data_Valid pulsed throughout a parity frame: all ignored.
    step(1'b0, 1'b1, 8'hC3, 1'b1, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b0, 1'b1, 8'($urandom), 1'($urandom), 1'($urandom));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("t6_len", 16'(last_len), 16'd11);
    check("t6_no_extra", 16'(busy), 16'h0);
    check("t6_par", 16'(Par_bit), 16'h1);

    // Random traffic with occasional resets.
    for (int i = 0; i < 600; i++)
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
           8'($urandom), 1'($urandom), 1'($urandom));
    idle(14);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
